// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch front end.
// Redirect codes, reset defaults and the fetch state encoding.
package mips_pkg;

    localparam logic [1:0] NPC_SEL_NONE = 2'b00;
    localparam logic [1:0] NPC_SEL_BR   = 2'b01;
    localparam logic [1:0] NPC_SEL_J    = 2'b10;
    localparam logic [1:0] NPC_SEL_JR   = 2'b11;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam logic [31:0] NOP      = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } if_state_t;

    // j/jal keep the upper PC region and drop in the word index
    function automatic logic [31:0] jump_addr(
        input logic [31:0] pc,
        input logic [25:0] index
    );
        return {pc[31:28], index, 2'b00};
    endfunction

endpackage

// File: rtl/npc_calc.sv
// Redirect target selection for the fetch stage.
// Purely combinational; falls back to pc+4 when no redirect.
module npc_calc
    import mips_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [1:0]  npc_sel,
    input  logic [31:0] branch_target,
    input  logic [25:0] jump_index,
    input  logic [31:0] jr_target,
    output logic [31:0] target
);

    always_comb begin
        target = pc + 32'd4;
        unique case (npc_sel)
            NPC_SEL_BR: target = branch_target;
            NPC_SEL_J:  target = jump_addr(pc, jump_index);
            NPC_SEL_JR: target = jr_target;
            default:    target = pc + 32'd4;
        endcase
    end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: one outstanding request, one-word buffer,
// and a single pending redirect so the delay slot is delivered first.
module if_stage #(
    parameter logic [31:0] RESET_PC = mips_pkg::RESET_PC,
    parameter logic [31:0] NOP      = mips_pkg::NOP
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [1:0]  npc_sel,
    input  logic [31:0] branch_target,
    input  logic [25:0] jump_index,
    input  logic [31:0] jr_target,
    output logic        im_req,
    output logic [31:0] im_addr,
    input  logic        im_valid,
    input  logic [31:0] im_rdata,
    output logic [31:0] pc,
    output logic [31:0] pc4,
    output logic [31:0] pc8,
    output logic [31:0] instr
);

    import mips_pkg::if_state_t;
    import mips_pkg::IDLE;
    import mips_pkg::WAIT;
    import mips_pkg::HOLD;
    import mips_pkg::NPC_SEL_NONE;

    if_state_t   state;
    if_state_t   state_nx;
    logic [31:0] word_q;
    logic        redir_pend;
    logic [31:0] redir_pc;

    logic        req_c;
    logic        avail;
    logic [31:0] word_c;
    logic        deliver;
    logic        accept;
    logic [31:0] target;
    logic [31:0] pc_nx;
    logic        pend_nx;
    logic [31:0] redir_pc_nx;

    npc_calc u_npc (
        .pc            (pc),
        .npc_sel       (npc_sel),
        .branch_target (branch_target),
        .jump_index    (jump_index),
        .jr_target     (jr_target),
        .target        (target)
    );

    always_comb begin
        state_nx = state;
        req_c    = 1'b0;
        avail    = 1'b0;
        word_c   = NOP;
        unique case (state)
            IDLE: begin
                req_c    = 1'b1;
                state_nx = WAIT;
            end
            WAIT: begin
                if (im_valid) begin
                    avail    = 1'b1;
                    word_c   = im_rdata;
                    state_nx = stall ? HOLD : IDLE;
                end
            end
            HOLD: begin
                avail  = 1'b1;
                word_c = word_q;
                if (!stall) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign deliver = avail & ~stall;

    // a second redirect while one is pending is a branch in a delay slot
    assign accept = (npc_sel != NPC_SEL_NONE) & ~stall & ~redir_pend;

    always_comb begin
        pc_nx       = pc + 32'd4;
        pend_nx     = redir_pend;
        redir_pc_nx = redir_pc;
        if (redir_pend) begin
            pc_nx = redir_pc;
        end else if (accept) begin
            pc_nx = target;
        end
        if (deliver) begin
            pend_nx     = 1'b0;
            redir_pc_nx = 32'd0;
        end else if (accept) begin
            pend_nx     = 1'b1;
            redir_pc_nx = target;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            pc4        <= RESET_PC + 32'd4;
            pc8        <= RESET_PC + 32'd8;
            redir_pend <= 1'b0;
            redir_pc   <= 32'd0;
            word_q     <= NOP;
        end else begin
            state      <= state_nx;
            redir_pend <= pend_nx;
            redir_pc   <= redir_pc_nx;
            if (deliver) begin
                pc  <= pc_nx;
                pc4 <= pc_nx + 32'd4;
                pc8 <= pc_nx + 32'd8;
            end
            if (state == WAIT && im_valid && stall) begin
                word_q <= im_rdata;
            end else if (state == HOLD && !stall) begin
                word_q <= NOP;
            end
        end
    end

    assign im_req  = req_c & ~reset;
    assign im_addr = pc;
    assign instr   = reset ? NOP : word_c;

endmodule
